ibex_mem_arbiter: RTL and testbench



---
 rtl/ibex_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_ibex_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_arbiter.sv
// Two-host to one-port arbiter for the Ibex req/gnt/rvalid protocol.
// An in-order ID FIFO routes every response back to the host that issued the request.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          FixedPrio      = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        h0_req_i,
  output logic        h0_gnt_o,
  input  logic [31:0] h0_addr_i,
  output logic        h0_rvalid_o,
  output logic [31:0] h0_rdata_o,
  output logic        h0_err_o,
  input  logic        h1_req_i,
  output logic        h1_gnt_o,
  input  logic [31:0] h1_addr_i,
  input  logic        h1_we_i,
  input  logic [3:0]  h1_be_i,
  input  logic [31:0] h1_wdata_i,
  output logic        h1_rvalid_o,
  output logic [31:0] h1_rdata_o,
  output logic        h1_err_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  input  logic        m_err_i,
  output logic        unexp_rsp_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  logic [MaxOutstanding-1:0] id_q, id_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      lock_q, lock_d, lock_sel_q, lock_sel_d;
  logic                      last_q, last_d, unexp_q, unexp_d;
  logic                      sel, req_sel, m_req, push, pop, head;

  // Host selection; a registered lock keeps an ungranted request stable.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (h0_req_i && h1_req_i) begin
      sel = FixedPrio ? 1'b1 : ~last_q;
    end else if (h1_req_i) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    req_sel = sel ? h1_req_i : h0_req_i;
    m_req   = req_sel & (cnt_q < CntMax) & ~rst_i;
  end

  assign push = m_req & m_gnt_i;
  assign pop  = m_rvalid_i & (cnt_q != '0) & ~rst_i;
  assign head = id_q[rptr_q];

  assign m_req_o   = m_req;
  assign m_addr_o  = sel ? h1_addr_i : h0_addr_i;
  assign m_we_o    = sel & h1_we_i;
  assign m_be_o    = sel ? h1_be_i : 4'hF;
  assign m_wdata_o = sel ? h1_wdata_i : 32'h0000_0000;

  assign h0_gnt_o    = push & ~sel;
  assign h1_gnt_o    = push & sel;
  assign h0_rvalid_o = pop & ~head;
  assign h1_rvalid_o = pop & head;
  assign h0_err_o    = m_err_i & h0_rvalid_o;
  assign h1_err_o    = m_err_i & h1_rvalid_o;
  assign h0_rdata_o  = m_rdata_i;
  assign h1_rdata_o  = m_rdata_i;
  assign unexp_rsp_o = unexp_q;

  // ID FIFO, last-winner, lock and sticky unexpected-response bookkeeping.
  always_comb begin
    id_d       = id_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    unexp_d    = unexp_q;
    lock_d     = m_req & ~m_gnt_i;
    lock_sel_d = sel;
    if (push) begin
      id_d[wptr_q] = sel;
      wptr_d       = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
      last_d       = sel;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (m_rvalid_i && (cnt_q == '0)) begin
      unexp_d = 1'b1;
    end else begin
      unexp_d = unexp_q;
    end
  end

  // State registers; last-winner resets to host 1 so host 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      last_q     <= 1'b1;
      unexp_q    <= 1'b0;
    end else begin
      id_q       <= id_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      last_q     <= last_d;
      unexp_q    <= unexp_d;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Randomized and directed bench for ibex_mem_arbiter: a negedge monitor checks the DUT
// against a queue-based reference model and a scoreboard of issued responses.
module tb_ibex_mem_arbiter;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        h0_req, h0_gnt, h0_rvalid, h0_err;
  logic [31:0] h0_addr, h0_rdata;
  logic        h1_req, h1_gnt, h1_we, h1_rvalid, h1_err;
  logic [3:0]  h1_be;
  logic [31:0] h1_addr, h1_wdata, h1_rdata;
  logic        m_req, m_gnt, m_we, m_rvalid, m_err, unexp;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  ibex_mem_arbiter #(.MaxOutstanding(MAX_OUT), .FixedPrio(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0_req), .h0_gnt_o(h0_gnt), .h0_addr_i(h0_addr),
    .h0_rvalid_o(h0_rvalid), .h0_rdata_o(h0_rdata), .h0_err_o(h0_err),
    .h1_req_i(h1_req), .h1_gnt_o(h1_gnt), .h1_addr_i(h1_addr), .h1_we_i(h1_we),
    .h1_be_i(h1_be), .h1_wdata_i(h1_wdata),
    .h1_rvalid_o(h1_rvalid), .h1_rdata_o(h1_rdata), .h1_err_o(h1_err),
    .m_req_o(m_req), .m_gnt_i(m_gnt), .m_addr_o(m_addr), .m_we_o(m_we),
    .m_be_o(m_be), .m_wdata_o(m_wdata),
    .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_err_i(m_err),
    .unexp_rsp_o(unexp)
  );

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  rsp_t rsp_q[$];
  int   host_q[$];
  int   m_last = 1;
  int   m_lock = -1;
  bit   m_unexp = 1'b0;
  int   mem_pend = 0;
  logic s_req, s_g0, s_g1, s_rv0, s_rv1, s_e0, s_e1, s_unexp;
  logic [31:0] s_addr;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: arbitration rules, in-order ID queue, sticky unexpected flag.
  task automatic mon_step();
    int   sel;
    int   h;
    bit   req;
    bit   have_r;
    bit   new_unexp;
    rsp_t r;
    have_r    = 1'b0;
    new_unexp = 1'b0;
    r         = '0;
    if (m_rvalid && rsp_q.size() > 0) begin
      r      = rsp_q.pop_front();
      have_r = 1'b1;
    end
    if (rst) begin
      chk1("rst_m_req", m_req, 1'b0);
      chk1("rst_h0_gnt", h0_gnt, 1'b0);
      chk1("rst_h1_gnt", h1_gnt, 1'b0);
      chk1("rst_h0_rvalid", h0_rvalid, 1'b0);
      chk1("rst_h1_rvalid", h1_rvalid, 1'b0);
      chk1("rst_unexp", unexp, 1'b0);
      host_q.delete();
      m_last  = 1;
      m_lock  = -1;
      m_unexp = 1'b0;
    end else begin
      if (m_lock >= 0) sel = m_lock;
      else if (h0_req && h1_req) sel = 1 - m_last;
      else if (h1_req) sel = 1;
      else sel = 0;
      req = ((sel == 1) ? h1_req : h0_req) && (host_q.size() < MAX_OUT);
      chk1("m_req", m_req, req);
      if (req) begin
        chk32("m_addr", m_addr, (sel == 1) ? h1_addr : h0_addr);
        chk1("m_we", m_we, (sel == 1) ? h1_we : 1'b0);
        chk32("m_be", {28'h0, m_be}, {28'h0, (sel == 1) ? h1_be : 4'hF});
        chk32("m_wdata", m_wdata, (sel == 1) ? h1_wdata : 32'h0);
      end
      chk1("h0_gnt", h0_gnt, req && m_gnt && (sel == 0));
      chk1("h1_gnt", h1_gnt, req && m_gnt && (sel == 1));
      if (m_rvalid && host_q.size() > 0) begin
        h = host_q.pop_front();
        chk1("h0_rvalid", h0_rvalid, h == 0);
        chk1("h1_rvalid", h1_rvalid, h == 1);
        if (have_r) begin
          chk32("rsp_rdata", (h == 0) ? h0_rdata : h1_rdata, r.rdata);
          chk1("rsp_err", (h == 0) ? h0_err : h1_err, r.err);
          chk1("other_err", (h == 0) ? h1_err : h0_err, 1'b0);
        end
      end else begin
        chk1("idle_h0_rvalid", h0_rvalid, 1'b0);
        chk1("idle_h1_rvalid", h1_rvalid, 1'b0);
        if (m_rvalid) new_unexp = 1'b1;
      end
      chk1("unexp", unexp, m_unexp);
      if (req && m_gnt) begin
        host_q.push_back(sel);
        m_last = sel;
        m_lock = -1;
      end else if (req) begin
        m_lock = sel;
      end else begin
        m_lock = -1;
      end
      if (new_unexp) m_unexp = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_step();
    end
  end

  // One clock of stimulus: log issued responses, sample outputs, move to next cycle.
  task automatic tick();
    if (m_rvalid) begin
      rsp_q.push_back({m_rdata, m_err});
      if (mem_pend > 0) mem_pend--;
    end
    #6;
    s_req = m_req;  s_addr = m_addr;  s_g0 = h0_gnt;  s_g1 = h1_gnt;
    s_rv0 = h0_rvalid;  s_rv1 = h1_rvalid;  s_e0 = h0_err;  s_e1 = h1_err;  s_unexp = unexp;
    if (m_req && m_gnt && !rst) mem_pend++;
    if (rst) mem_pend = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h0_req = 1'b0; h0_addr = 32'h0;
    h1_req = 1'b0; h1_addr = 32'h0; h1_we = 1'b0; h1_be = 4'h0; h1_wdata = 32'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_random(input int n, input bit new_req);
    for (int i = 0; i < n; i++) begin
      if (!h0_req || s_g0) begin
        h0_req  = new_req && ($urandom_range(3) != 0);
        h0_addr = $urandom;
      end
      if (!h1_req || s_g1) begin
        h1_req   = new_req && ($urandom_range(3) != 0);
        h1_addr  = $urandom;
        h1_we    = 1'($urandom_range(1));
        h1_be    = 4'($urandom_range(15));
        h1_wdata = $urandom;
      end
      m_gnt = new_req ? ($urandom_range(3) != 0) : 1'b1;
      if (mem_pend > 0 && $urandom_range(1) == 1) begin
        m_rvalid = 1'b1;
        m_rdata  = $urandom;
        m_err    = ($urandom_range(7) == 0);
      end else begin
        m_rvalid = 1'b0;
        m_err    = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    h0_req = 1'b1; h1_req = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b1;
    tick();
    tick();
    do_reset();
    chk1("reset_unexp", s_unexp, 1'b0);
    chk1("reset_m_req", s_req, 1'b0);

    for (int i = 0; i < 6; i++) begin
      h0_req = 1'b1; h0_addr = 32'h1000 + 32'(i * 4); m_gnt = 1'b1;
      m_rvalid = (i > 0); m_rdata = 32'(i);
      tick();
      chk1("single_h0_gnt", s_g0, 1'b1);
      chk1("single_h1_gnt", s_g1, 1'b0);
      if (i > 0) chk1("single_h0_rvalid", s_rv0, 1'b1);
    end
    h0_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    tick();

    do_reset();
    for (int i = 0; i < 4; i++) begin
      h0_req = 1'b1; h0_addr = 32'h2000 + 32'(i);
      h1_req = 1'b1; h1_addr = 32'h3000 + 32'(i);
      m_gnt = 1'b1; m_rvalid = (i > 0); m_rdata = 32'hA + 32'(i) - 32'h1;
      tick();
      chk1("contend_h0_gnt", s_g0, (i % 2) == 0);
      chk1("contend_h1_gnt", s_g1, (i % 2) == 1);
      if (i > 0) chk1("contend_h0_rvalid", s_rv0, (i % 2) == 1);
    end
    h0_req = 1'b0; h1_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hD;
    tick();
    chk1("contend_last_h1_rvalid", s_rv1, 1'b1);

    do_reset();
    h0_req = 1'b1; h0_addr = 32'h10; m_gnt = 1'b1;
    tick();
    h0_addr = 32'h100; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55;
    tick();
    chk32("lock_addr_first", s_addr, 32'h100);
    m_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      h1_req = 1'b1; h1_addr = 32'h200;
      tick();
      chk32("lock_addr_held", s_addr, 32'h100);
      chk1("lock_h1_no_gnt", s_g1, 1'b0);
    end
    m_gnt = 1'b1;
    tick();
    chk1("lock_h0_gnt", s_g0, 1'b1);
    chk32("lock_addr_gnt", s_addr, 32'h100);
    h0_req = 1'b0;
    tick();
    chk1("lock_h1_next", s_g1, 1'b1);
    chk32("lock_h1_addr", s_addr, 32'h200);
    h1_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    tick();
    tick();
    m_rvalid = 1'b0;

    do_reset();
    h0_req = 1'b1; m_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      h0_addr = 32'h4000 + 32'(i);
      tick();
      chk1("full_fill_gnt", s_g0, 1'b1);
    end
    tick();
    chk1("full_m_req_low", s_req, 1'b0);
    m_rvalid = 1'b1;
    tick();
    chk1("full_pop_m_req_low", s_req, 1'b0);
    m_rvalid = 1'b0;
    tick();
    chk1("full_m_req_back", s_req, 1'b1);
    chk1("full_gnt_back", s_g0, 1'b1);
    h0_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    tick();
    tick();
    m_rvalid = 1'b0;

    do_reset();
    h1_req = 1'b1; h1_we = 1'b1; h1_be = 4'h3; h1_wdata = 32'hDEAD; h1_addr = 32'h40; m_gnt = 1'b1;
    tick();
    chk1("err_h1_gnt", s_g1, 1'b1);
    h1_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_err = 1'b1; m_rdata = 32'h77;
    tick();
    chk1("err_h1_rvalid", s_rv1, 1'b1);
    chk1("err_h1_err", s_e1, 1'b1);
    chk1("err_h0_err", s_e0, 1'b0);
    chk1("err_h0_rvalid", s_rv0, 1'b0);
    m_rvalid = 1'b0; m_err = 1'b0;

    do_reset();
    m_rvalid = 1'b1;
    tick();
    chk1("unexp_no_rv0", s_rv0, 1'b0);
    chk1("unexp_no_rv1", s_rv1, 1'b0);
    m_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("unexp_sticky", s_unexp, 1'b1);
    end

    do_reset();
    h0_req = 1'b1; m_gnt = 1'b1;
    tick();
    h0_req = 1'b0; m_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk1("rstmid_unexp_clear", s_unexp, 1'b0);
    m_rvalid = 1'b1;
    tick();
    chk1("rstmid_no_rv0", s_rv0, 1'b0);
    m_rvalid = 1'b0;
    tick();
    chk1("rstmid_unexp_set", s_unexp, 1'b1);

    do_reset();
    run_random(3000, 1'b1);
    run_random(60, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
